// File: rtl/cpu_clock_sequencer.sv
// cpu_clock_sequencer
//   Derives the 6502 phi clock from CLOCK_50 and sequences the CPU through
//   reset stretching, free-run and single-step operation. It also counts
//   completed CPU bus cycles.
//
// Ports
//   CLOCK_50    in   system clock, all state on its rising edge
//   res         in   asynchronous active-high reset
//   run_mode    in   1 = free run, 0 = single step (sampled on phi falling edges)
//   step_n      in   raw active-low step key, asynchronous to CLOCK_50
//   phi         out  CPU clock, 50% duty, period 2*HALF_PERIOD
//   phi_rise    out  one-cycle pulse in the first CLOCK_50 cycle with phi=1
//   phi_fall    out  one-cycle pulse in the first CLOCK_50 cycle with phi=0
//   cpu_res_n   out  active-low CPU reset
//   rdy         out  CPU ready
//   cycle_count out  completed CPU cycles, wraps at 16 bits
module cpu_clock_sequencer #(
    parameter int HALF_PERIOD = 100,
    parameter int RES_CYCLES  = 8,
    parameter int DEBOUNCE    = 50000
) (
    input  logic        CLOCK_50,
    input  logic        res,
    input  logic        run_mode,
    input  logic        step_n,
    output logic        phi,
    output logic        phi_rise,
    output logic        phi_fall,
    output logic        cpu_res_n,
    output logic        rdy,
    output logic [15:0] cycle_count
);

    localparam int DIV_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int HOLD_W = $clog2(RES_CYCLES + 1);
    localparam int DEB_W  = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2,
        STEP_GO   = 2'd3
    } state_t;

    // phase divider
    logic [DIV_W-1:0] div_q, div_d;
    logic             phi_q, rise_q, fall_q;
    logic             wrap, fall_tick, rise_tick;

    // step key conditioning
    logic             sync1_q, sync2_q;
    logic             deb_lvl_q, deb_lvl_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press_q, press_d;

    // sequencer
    state_t            state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              res_n_q, rdy_q, pend_q;
    logic [15:0]       cnt_q;

    // fall_tick/rise_tick mark the clock edge on which phi itself toggles;
    // every sequencer decision is taken on fall_tick so rdy and cpu_res_n
    // only ever move together with the phi falling edge.
    assign wrap      = (div_q == DIV_W'(HALF_PERIOD - 1));
    assign fall_tick = wrap & phi_q;
    assign rise_tick = wrap & ~phi_q;
    assign div_d     = wrap ? '0 : div_q + DIV_W'(1);

    always_comb begin
        deb_lvl_d = deb_lvl_q;
        deb_cnt_d = '0;
        press_d   = 1'b0;
        if (sync2_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE - 1)) begin
                deb_lvl_d = sync2_q;
                // only a debounced 1->0 change is a press
                press_d   = ~sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge res) begin
        if (res) begin
            div_q     <= '0;
            phi_q     <= 1'b1;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_lvl_q <= 1'b1;
            deb_cnt_q <= '0;
            press_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            phi_q     <= wrap ? ~phi_q : phi_q;
            rise_q    <= rise_tick;
            fall_q    <= fall_tick;
            sync1_q   <= step_n;
            sync2_q   <= sync1_q;
            deb_lvl_q <= deb_lvl_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge res) begin
        if (res) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
            res_n_q    <= 1'b0;
            rdy_q      <= 1'b1;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // a bus cycle completes when the CPU was out of reset and ready
            // for the whole phi period that is now ending
            if (fall_tick && res_n_q && rdy_q) begin
                cnt_q <= cnt_q + 16'd1;
            end

            case (state_q)
                HOLD: begin
                    if (fall_tick) begin
                        if (hold_cnt_q == HOLD_W'(RES_CYCLES - 1)) begin
                            res_n_q <= 1'b1;
                            if (run_mode) begin
                                state_q <= RUN;
                            end else begin
                                state_q <= STEP_WAIT;
                                rdy_q   <= 1'b0;
                            end
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (fall_tick && !run_mode) begin
                        state_q <= STEP_WAIT;
                        rdy_q   <= 1'b0;
                    end
                end
                STEP_WAIT: begin
                    if (press_q) begin
                        pend_q <= 1'b1;
                    end
                    // a press arriving on the same edge as the fall still
                    // counts, hence press_q is ORed with the pending flag
                    if (fall_tick) begin
                        if (run_mode) begin
                            state_q <= RUN;
                            rdy_q   <= 1'b1;
                            pend_q  <= 1'b0;
                        end else if (pend_q || press_q) begin
                            state_q <= STEP_GO;
                            rdy_q   <= 1'b1;
                            pend_q  <= 1'b0;
                        end
                    end
                end
                STEP_GO: begin
                    // presses here are dropped: pend_q is only set in STEP_WAIT
                    if (fall_tick) begin
                        state_q <= run_mode ? RUN : STEP_WAIT;
                        rdy_q   <= run_mode;
                    end
                end
                default: begin
                    state_q <= HOLD;
                end
            endcase
        end
    end

    assign phi         = phi_q;
    assign phi_rise    = rise_q;
    assign phi_fall    = fall_q;
    assign cpu_res_n   = res_n_q;
    assign rdy         = rdy_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
module tb_cpu_clock_sequencer;

    localparam int HP  = 4;
    localparam int RC  = 2;
    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        run_mode = 1'b1;
    logic        step_n = 1'b1;
    logic        phi, phi_rise, phi_fall, cpu_res_n, rdy;
    logic [15:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_clock_sequencer #(
        .HALF_PERIOD(HP),
        .RES_CYCLES (RC),
        .DEBOUNCE   (DEB)
    ) dut (
        .CLOCK_50   (clk),
        .res        (res),
        .run_mode   (run_mode),
        .step_n     (step_n),
        .phi        (phi),
        .phi_rise   (phi_rise),
        .phi_fall   (phi_fall),
        .cpu_res_n  (cpu_res_n),
        .rdy        (rdy),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // expected {phi, phi_rise, phi_fall, cpu_res_n, rdy, cycle_count}
    // after a given clock edge counted from reset release (run_mode=1)
    typedef struct {
        int          edge_n;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [20:0] obs();
        return {phi, phi_rise, phi_fall, cpu_res_n, rdy, cycle_count};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_res();
        @(negedge clk);
        res = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        res = 1'b1;
        tick();
        tick();
        release_res();
    endtask

    task automatic wait_fall(input string nm);
        int g;
        g = 0;
        tick();
        while (phi_fall !== 1'b1 && g < 20) begin
            tick();
            g++;
        end
        chk({nm, " fall seen"}, {31'b0, phi_fall}, 32'd1);
    endtask

    task automatic run_table(input string nm);
        int cur;
        cur = 0;
        for (int i = 0; i < 11; i++) begin
            while (cur < tbl[i].edge_n) begin
                tick();
                cur++;
            end
            chk($sformatf("%s edge %0d", nm, tbl[i].edge_n), {11'b0, obs()}, {11'b0, tbl[i].exp});
        end
    endtask

    // press step_n right after a phi fall E for 10 clocks:
    // press event after E+5, pending after E+6, STEP_GO from E+8 to E+15
    task automatic press_step(input string nm);
        logic [15:0] c0;
        wait_fall(nm);
        c0 = cycle_count;
        step_n = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 10) step_n = 1'b1;
            chk($sformatf("%s rdy k%0d", nm, k), {31'b0, rdy}, {31'b0, (k >= 8 && k <= 15)});
            if (k == 8) chk({nm, " rdy on fall"}, {31'b0, phi_fall}, 32'd1);
        end
        chk({nm, " count"}, {16'b0, cycle_count}, {16'b0, c0 + 16'd1});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c0;
        int          hi;
        logic        glitch [12];

        tbl[0]  = '{0,  {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0}};
        tbl[1]  = '{3,  {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0}};
        tbl[2]  = '{4,  {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0}};
        tbl[3]  = '{5,  {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0}};
        tbl[4]  = '{8,  {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0}};
        tbl[5]  = '{11, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0}};
        tbl[6]  = '{12, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd0}};
        tbl[7]  = '{19, {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0}};
        tbl[8]  = '{20, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1}};
        tbl[9]  = '{21, {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1}};
        tbl[10] = '{28, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2}};

        glitch = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // reset release in free run
        run_mode = 1'b1;
        do_reset();
        run_table("s1");

        // counter wrap and pulse widths/spacing
        wait_fall("s2");
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        chk("s2 preset", {16'b0, cycle_count}, 32'h0000FFFF);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("s2 fall i%0d", i), {31'b0, phi_fall}, {31'b0, (i % 8 == 0)});
            chk($sformatf("s2 rise i%0d", i), {31'b0, phi_rise}, {31'b0, (i % 8 == 4)});
            if (i == 8)  chk("s2 wrap", {16'b0, cycle_count}, 32'd0);
            if (i == 16) chk("s2 after wrap", {16'b0, cycle_count}, 32'd1);
        end

        // single step from reset
        run_mode = 1'b0;
        do_reset();
        repeat (11) tick();
        chk("s3 rdy e11", {31'b0, rdy}, 32'd1);
        tick();
        chk("s3 rdy e12", {31'b0, rdy}, 32'd0);
        chk("s3 res_n e12", {31'b0, cpu_res_n}, 32'd1);
        press_step("s3a");
        press_step("s3b");

        // press event on the same edge as phi fall
        wait_fall("same");
        tick();
        tick();
        step_n = 1'b0;
        for (int k = 3; k <= 16; k++) begin
            tick();
            if (k == 7) begin
                step_n = 1'b1;
                chk("same rdy e7", {31'b0, rdy}, 32'd0);
            end
            if (k == 8)  chk("same rdy e8", {31'b0, rdy}, 32'd1);
            if (k == 15) chk("same rdy e15", {31'b0, rdy}, 32'd1);
            if (k == 16) chk("same rdy e16", {31'b0, rdy}, 32'd0);
        end

        // glitch and bounce: never three consecutive synced lows
        wait_fall("s4g");
        c0 = cycle_count;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step_n = glitch[i];
            tick();
            if (rdy) hi++;
        end
        step_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (rdy) hi++;
        end
        chk("s4 glitch rdy", hi, 0);
        chk("s4 glitch count", {16'b0, cycle_count}, {16'b0, c0});

        // second press during STEP_GO is dropped
        wait_fall("s4d");
        c0 = cycle_count;
        step_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 4)  step_n = 1'b1;
            if (k == 9)  step_n = 1'b0;
            if (k == 13) step_n = 1'b1;
            chk($sformatf("s4d rdy k%0d", k), {31'b0, rdy}, {31'b0, (k >= 8 && k <= 15)});
        end
        chk("s4d count", {16'b0, cycle_count}, {16'b0, c0 + 16'd1});

        // run_mode changes take effect only at phi fall
        wait_fall("s5");
        tick();
        tick();
        run_mode = 1'b1;
        repeat (5) tick();
        chk("s5 rdy e7", {31'b0, rdy}, 32'd0);
        tick();
        chk("s5 rdy e8", {31'b0, rdy}, 32'd1);
        tick();
        tick();
        run_mode = 1'b0;
        repeat (5) tick();
        chk("s5 rdy e15", {31'b0, rdy}, 32'd1);
        tick();
        chk("s5 rdy e16", {31'b0, rdy}, 32'd0);

        // asynchronous reset mid phase while running
        run_mode = 1'b1;
        wait_fall("s6a");
        wait_fall("s6b");
        tick();
        tick();
        chk("s6 count nonzero", {31'b0, (cycle_count != 16'd0)}, 32'd1);
        res = 1'b1;
        #1;
        chk("s6 async reset", {11'b0, obs()}, {11'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0});
        tick();
        release_res();
        run_table("s6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_clock_sequencer.md
# cpu_clock_sequencer

Generates the 6502 `phi` clock from CLOCK_50 and sequences the CPU through reset stretching, free-run and single-step operation. Sits between the board inputs (KEY, switches) and `chip_6502`/`single_port_rom`, driving `phi`, the CPU reset and `rdy`. Also counts completed CPU bus cycles for LED/debug display.

## Interface
- HALF_PERIOD, 100: CLOCK_50 cycles per `phi` half-period (≥2).
- RES_CYCLES, 8: `phi` falling edges for which `cpu_res_n` stays low after `res` release (≥1).
- DEBOUNCE, 50000: CLOCK_50 cycles `step_n` must be stable before a level change is accepted (≥1).

- CLOCK_50  input  1  system clock; all state on rising edge.
- res  input  1  reset; asynchronous, active-high.
- run_mode  input  1  1 = free run, 0 = single step; sampled only on `phi_fall`.
- step_n  input  1  raw step key, active-low, asynchronous to CLOCK_50.
- phi  output  1  CPU clock, 50% duty, period 2×HALF_PERIOD.
- phi_rise  output  1  one-cycle pulse, high in the first CLOCK_50 cycle with `phi`=1.
- phi_fall  output  1  one-cycle pulse, high in the first CLOCK_50 cycle with `phi`=0.
- cpu_res_n  output  1  active-low CPU reset.
- rdy  output  1  CPU ready.
- cycle_count  output  16  completed CPU cycles, wraps.

## Operation
- Phase divider: counter 0..HALF_PERIOD-1; at HALF_PERIOD-1 counter→0 and `phi` toggles. It runs in all states except under `res`.
- Step input: 2-flop synchronizer, then debounce counter. The debounced level changes after DEBOUNCE consecutive cycles of a differing synced value. A press event is a debounced 1→0 transition, one clock wide.
- States:
  - HOLD: `cpu_res_n`=0, `rdy`=1. Counts `phi_fall`; on the RES_CYCLES-th, `cpu_res_n`→1 and the state goes to RUN if `run_mode`=1, else to STEP_WAIT.
  - RUN: `rdy`=1. On `phi_fall` with `run_mode`=0 → STEP_WAIT with `rdy`→0.
  - STEP_WAIT: `rdy`=0. A press event sets a pending flag. On `phi_fall`: if `run_mode`=1 → RUN with `rdy`→1; else if pending → STEP_GO with `rdy`→1 and the flag cleared.
  - STEP_GO: `rdy`=1 for exactly one `phi` period. On the next `phi_fall` → STEP_WAIT with `rdy`→0, or → RUN if `run_mode`=1.
  - Press events outside STEP_WAIT are discarded (not queued).
- `rdy` and `cpu_res_n` change only on `phi_fall` clock edges, so they are stable across `phi` high.
- `cycle_count` increments on `phi_fall` when `cpu_res_n`=1 and `rdy`=1 (both pre-edge values). It wraps 16'hFFFF→0.

## Timing
- Under `res`: `phi`=1, divider=0, `phi_rise`=0, `phi_fall`=0, `cpu_res_n`=0, `rdy`=1, `cycle_count`=0, state HOLD, HOLD count=0, synchronizer/debounced level=1, debounce count=0, pending=0.
- After `res` release, the first `phi` falling edge occurs on the HALF_PERIOD-th clock edge. Subsequent `phi` toggles occur every HALF_PERIOD edges.
- `cpu_res_n` rises on edge (2·RES_CYCLES−1)·HALF_PERIOD after release.
- Step latency, press to `rdy`=1: 2 (sync) + DEBOUNCE + 1 edges to the pending flag, then up to 2×HALF_PERIOD to the next `phi_fall`.
- A press event and `phi_fall` on the same edge in STEP_WAIT: the event counts for that `phi_fall` → STEP_GO.
- `res` asserted mid-operation: all outputs go to reset values immediately (asynchronous), regardless of state or phase.
- `run_mode` toggling between `phi_fall` edges has no effect until the next `phi_fall`.

## Test plan
Parameters for all scenarios: HALF_PERIOD=4, RES_CYCLES=2, DEBOUNCE=3.
1. Reset release with `run_mode`=1 → `phi` falls at edge 4 and rises at edge 8; `cpu_res_n`=1 at edge 12; `rdy` stays 1; `cycle_count`=1 after edge 20.
2. Free run for 65536 counted `phi_fall` edges, forcing `cycle_count` to 16'hFFFF → next count 16'h0000; `phi_rise`/`phi_fall` each exactly one clock wide, 8 clocks apart.
3. `run_mode`=0 after reset → `rdy`=0 from edge 12. A `step_n` low for 10 clocks → `rdy`=1 for exactly 8 clocks, starting on a `phi_fall`; `cycle_count` +1 per step.
4. `step_n` glitch low for 2 clocks, plus a bounce pattern → no press event, `rdy` stays 0. A second press during STEP_GO → discarded, only one cycle advances.
5. In STEP_WAIT, set `run_mode`=1 mid-phase → `rdy`→1 only at the next `phi_fall`. Clear `run_mode` → `rdy`→0 at the following `phi_fall`.
6. Assert `res` 2 clocks into a `phi`-low phase during RUN → same clock: `phi`=1, `cpu_res_n`=0, `cycle_count`=0. Release → scenario 1 timing repeats exactly.
